// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD pixel reader: FSM states, FIFO word
// layout and default panel timing (480x272 panel).
package lcd_pkg;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int RGB_MSB = 23;
  localparam int SOF_BIT = 24;
  localparam int DATA_W  = RGB_MSB + 1;
  localparam int CNT_W   = 11;

  localparam int DEF_H_ACTIVE        = 480;
  localparam int DEF_H_FP            = 8;
  localparam int DEF_H_SYNC          = 4;
  localparam int DEF_H_BP            = 43;
  localparam int DEF_V_ACTIVE        = 272;
  localparam int DEF_V_FP            = 4;
  localparam int DEF_V_SYNC          = 4;
  localparam int DEF_V_BP            = 12;
  localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/lcd_timing_gen.sv
// Raster counters for the pixel clock domain; decodes the active window,
// sync pulses (polarity-neutral, high = asserted) and the (0,0) frame start.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic i_clock,
  input  logic i_resetN,
  output logic o_active,
  output logic o_hsyncOn,
  output logic o_vsyncOn,
  output logic o_frameStart
);

  // Both totals must fit the 11-bit counters (<= 2048).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;

  always_ff @(posedge i_clock) begin
    if (!i_resetN) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hCount == H_LAST) begin
      hCount <= '0;
      vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
    end else begin
      hCount <= hCount + 1'b1;
    end
  end

  assign o_active     = (hCount < H_VIS) && (vCount < V_VIS);
  assign o_hsyncOn    = (hCount >= HS_START) && (hCount < HS_END);
  assign o_vsyncOn    = (vCount >= VS_START) && (vCount < VS_END);
  assign o_frameStart = (hCount == '0) && (vCount == '0);

endmodule

// File: rtl/lcd_pixel_reader.sv
// FIFO consumer that locks frames to the SOF marker and drives the LCD panel;
// underflow and misaligned frames blank to black without stalling the raster.
module lcd_pixel_reader
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
  input  logic              i_clock,
  input  logic              i_resetN,
  input  logic [31:0]       i_fifoData,
  input  logic              i_fifoEmpty,
  output logic              o_fifoRead,
  output logic [DATA_W-1:0] o_rgb,
  output logic              o_de,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_underflow,
  output logic              o_frameError
);

  function automatic logic syncLevel(input logic asserted);
    return SYNC_ACTIVE_LOW ? !asserted : asserted;
  endfunction

  logic active;
  logic hsyncOn;
  logic vsyncOn;
  logic frameStart;

  lcd_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) uTiming (
    .i_clock     (i_clock),
    .i_resetN    (i_resetN),
    .o_active    (active),
    .o_hsyncOn   (hsyncOn),
    .o_vsyncOn   (vsyncOn),
    .o_frameStart(frameStart)
  );

  logic              headSof;
  logic [DATA_W-1:0] headRgb;
  logic              unusedHighBits;

  assign headSof        = i_fifoData[SOF_BIT];
  assign headRgb        = i_fifoData[RGB_MSB:0];
  assign unusedHighBits = ^i_fifoData[31:SOF_BIT+1];

  state_t state;
  state_t nextState;

  logic pixelSlot;
  logic sofFault;
  logic popPixel;
  logic seekDiscard;
  logic underflowHit;

  always_ff @(posedge i_clock) begin
    if (!i_resetN) state <= SEEK;
    else           state <= nextState;
  end

  // ARMED at (0,0) already behaves as RUN so the held SOF word is shown there.
  always_comb begin
    nextState = state;
    case (state)
      SEEK:    if (!i_fifoEmpty && headSof) nextState = ARMED;
      ARMED:   if (frameStart) nextState = sofFault ? SEEK : RUN;
      RUN:     if (sofFault) nextState = SEEK;
      default: nextState = SEEK;
    endcase
  end

  always_comb begin
    pixelSlot    = active && ((state == RUN) || ((state == ARMED) && frameStart));
    sofFault     = pixelSlot && !i_fifoEmpty && (frameStart ? !headSof : headSof);
    popPixel     = pixelSlot && !i_fifoEmpty && !sofFault;
    seekDiscard  = (state == SEEK) && !i_fifoEmpty && !headSof;
    underflowHit = pixelSlot && i_fifoEmpty;
    o_fifoRead   = i_resetN && (popPixel || seekDiscard);
  end

  logic [DATA_W-1:0] rgb_p1;
  logic              vld_p1;
  logic              hsync_p1;
  logic              vsync_p1;
  logic              underflow;
  logic              frameError;

  // ---- stage p1: registered panel outputs, one clock behind the counters ----
  always_ff @(posedge i_clock) begin
    if (!i_resetN) begin
      rgb_p1     <= '0;
      vld_p1     <= 1'b0;
      hsync_p1   <= syncLevel(1'b0);
      vsync_p1   <= syncLevel(1'b0);
      underflow  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      rgb_p1     <= popPixel ? headRgb : '0;
      vld_p1     <= active;
      hsync_p1   <= syncLevel(hsyncOn);
      vsync_p1   <= syncLevel(vsyncOn);
      underflow  <= underflow | underflowHit;
      frameError <= frameError | sofFault;
    end
  end

  assign o_rgb        = rgb_p1;
  assign o_de         = vld_p1;
  assign o_hsync      = hsync_p1;
  assign o_vsync      = vsync_p1;
  assign o_underflow  = underflow;
  assign o_frameError = frameError;

endmodule
